// File: rtl/parity_stream_checker.sv
// Parity checker on a streaming word path, with one forwarding register and error statistics.
// Latency: one cycle from accept to out_*; status registers update on the accept edge.
// Backpressure: in_ready = !out_valid || out_ready, so a stalled output register holds its word and blocks input.
module parity_stream_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_odd,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_error,
    output logic              sticky_err,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count,
    output logic [DATA_W-1:0] first_err_data
);

    // Forwarded word together with its check result.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              error;
    } word_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    word_t             out_word;
    logic              accept;
    logic              word_err;
    logic              sticky_nxt;
    logic [CNT_W-1:0]  err_nxt;
    logic [CNT_W-1:0]  word_nxt;
    logic [DATA_W-1:0] first_nxt;

    // The output register can take a new word when empty or when it drains this cycle.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    // Total ones over data+parity must be even in even mode and odd in odd mode.
    assign word_err  = (^{in_data, in_parity}) ^ mode_odd;
    assign out_data  = out_word.data;
    assign out_error = out_word.error;

    // Single-stage forwarding register: load on accept, empty on a transfer with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= '0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_word.data  <= in_data;
            out_word.error <= word_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Next status values: clear is applied first, then the accepted word is counted on top.
    always_comb begin
        sticky_nxt = clear ? 1'b0 : sticky_err;
        err_nxt    = clear ? '0   : err_count;
        word_nxt   = clear ? '0   : word_count;
        first_nxt  = clear ? '0   : first_err_data;
        if (accept) begin
            word_nxt = word_nxt + CNT_ONE;
            if (word_err) begin
                if (err_nxt != CNT_MAX) begin
                    err_nxt = err_nxt + CNT_ONE;
                end
                // Capture only the first failure since reset/clear.
                if (!sticky_nxt) begin
                    first_nxt = in_data;
                end
                sticky_nxt = 1'b1;
            end
        end
    end

    // Status registers for software inspection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_err     <= 1'b0;
            err_count      <= '0;
            word_count     <= '0;
            first_err_data <= '0;
        end else begin
            sticky_err     <= sticky_nxt;
            err_count      <= err_nxt;
            word_count     <= word_nxt;
            first_err_data <= first_nxt;
        end
    end

endmodule
